// File: rtl/row_sum_accum_if.sv
// Pixel-stream input and row-sum result bundle for row_sum_accum.
// The slave modport is the accumulator's view; master is the driving side.
interface row_sum_accum_if;
   logic        sof;
   logic        eol;
   logic        pix_valid;
   logic        pix_fg;
   logic [10:0] sum_row_out;
   logic        sum_valid;
   logic        sat_flag;
   logic        frame_err;

   modport slave (
      input  sof, eol, pix_valid, pix_fg,
      output sum_row_out, sum_valid, sat_flag, frame_err
   );

   modport master (
      output sof, eol, pix_valid, pix_fg,
      input  sum_row_out, sum_valid, sat_flag, frame_err
   );
endinterface

// File: rtl/row_sum_accum.sv
// Counts foreground pixels inside a rectangular window per frame and publishes
// the saturated count at each clean frame end; malformed frames pulse frame_err.
module row_sum_accum #(
   parameter int FRAME_W = 640,
   parameter int FRAME_H = 480,
   parameter int WIN_X0  = 0,
   parameter int WIN_X1  = 640,
   parameter int WIN_Y0  = 240,
   parameter int WIN_Y1  = 241,
   parameter int SAT_MAX = 2047
) (
   input  logic            dclk,
   input  logic            clr,
   row_sum_accum_if.slave  bus
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   localparam logic [9:0]  FW     = 10'(FRAME_W);
   localparam logic [9:0]  FW_M1  = 10'(FRAME_W - 1);
   localparam logic [8:0]  FH_M1  = 9'(FRAME_H - 1);
   localparam logic [9:0]  WX0    = 10'(WIN_X0);
   localparam logic [9:0]  WX1    = 10'(WIN_X1);
   localparam logic [8:0]  WY0    = 9'(WIN_Y0);
   localparam logic [8:0]  WY1    = 9'(WIN_Y1);
   localparam logic [10:0] SAT11  = 11'(SAT_MAX);
   localparam logic [11:0] SAT12  = {1'b0, SAT11};
   // The sof pixel is always (0,0), so its window membership is a constant.
   localparam logic ORIGIN_IN = (WIN_X0 == 0) && (WIN_X1 > 0) &&
                                (WIN_Y0 == 0) && (WIN_Y1 > 0);

   state_t      state_q, state_d;
   logic [9:0]  x_q, x_d;
   logic [8:0]  y_q, y_d;
   logic [10:0] acc_q, acc_d;
   logic [10:0] sum_q, sum_d;
   logic        sat_q, sat_d;
   logic        sv_q, sv_d;
   logic        err_q, err_d;

   logic        in_win;
   logic        inc;
   logic [11:0] acc_sum;
   logic [10:0] acc_sat;

   always_comb begin
      in_win  = (x_q >= WX0) && (x_q < WX1) && (y_q >= WY0) && (y_q < WY1);
      inc     = bus.pix_fg & in_win;
      acc_sum = {1'b0, acc_q} + {11'b0, inc};
      acc_sat = (acc_sum > SAT12) ? SAT11 : acc_sum[10:0];
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      sat_d   = sat_q;
      sv_d    = 1'b0;
      err_d   = 1'b0;

      if (bus.pix_valid) begin
         if (bus.sof) begin
            // sof wins over a coincident eol and restarts any frame in flight.
            err_d   = (state_q == ACTIVE);
            acc_d   = {10'b0, bus.pix_fg & ORIGIN_IN};
            x_d     = 10'd1;
            y_d     = '0;
            state_d = ACTIVE;
         end else if (state_q == ACTIVE) begin
            if ((x_q == FW) || (bus.eol && (x_q != FW_M1))) begin
               err_d   = 1'b1;
               x_d     = '0;
               y_d     = '0;
               acc_d   = '0;
               state_d = IDLE;
            end else begin
               acc_d = acc_sat;
               x_d   = x_q + 10'd1;
               if (bus.eol) begin
                  if (y_q != FH_M1) begin
                     x_d = '0;
                     y_d = y_q + 9'd1;
                  end else begin
                     sum_d   = acc_sat;
                     sat_d   = (acc_sat == SAT11);
                     sv_d    = 1'b1;
                     x_d     = '0;
                     y_d     = '0;
                     acc_d   = '0;
                     state_d = IDLE;
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge dclk or posedge clr) begin
      if (clr) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         sat_q   <= 1'b0;
         sv_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         sat_q   <= sat_d;
         sv_q    <= sv_d;
         err_q   <= err_d;
      end
   end

   assign bus.sum_row_out = sum_q;
   assign bus.sum_valid   = sv_q;
   assign bus.sat_flag    = sat_q;
   assign bus.frame_err   = err_q;

endmodule

// File: tb/tb_row_sum_accum.sv
// Directed bench for row_sum_accum on a reduced 64x64 frame: a single-row window
// instance (A) and a half-frame window instance (B) that saturates.
module tb_row_sum_accum;

   localparam int FW = 64;
   localparam int FH = 64;

   logic dclk = 1'b0;
   logic clr  = 1'b1;
   logic sof  = 1'b0;
   logic eol  = 1'b0;
   logic pv   = 1'b0;
   logic fg   = 1'b0;

   int checks = 0;
   int errors = 0;
   int sv_a = 0, sv_b = 0, er_a = 0, er_b = 0;
   int err_sum_a = -1;

   always #5 dclk = ~dclk;

   row_sum_accum_if ifa ();
   row_sum_accum_if ifb ();

   assign ifa.sof = sof;  assign ifa.eol = eol;  assign ifa.pix_valid = pv;  assign ifa.pix_fg = fg;
   assign ifb.sof = sof;  assign ifb.eol = eol;  assign ifb.pix_valid = pv;  assign ifb.pix_fg = fg;

   row_sum_accum #(.FRAME_W(FW), .FRAME_H(FH), .WIN_X0(0), .WIN_X1(64),
                   .WIN_Y0(32), .WIN_Y1(33), .SAT_MAX(2047))
      u_a (.dclk(dclk), .clr(clr), .bus(ifa.slave));

   row_sum_accum #(.FRAME_W(FW), .FRAME_H(FH), .WIN_X0(0), .WIN_X1(64),
                   .WIN_Y0(32), .WIN_Y1(64), .SAT_MAX(2047))
      u_b (.dclk(dclk), .clr(clr), .bus(ifb.slave));

   always @(negedge dclk) begin
      if (ifa.sum_valid) sv_a++;
      if (ifb.sum_valid) sv_b++;
      if (ifa.frame_err) begin
         er_a++;
         err_sum_a = int'(ifa.sum_row_out);
      end
      if (ifb.frame_err) er_b++;
   end

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic s, input logic e, input logic f);
      @(negedge dclk);
      pv = v; sof = s; eol = e; fg = f;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   function automatic logic fg_of(input int mode, input int x);
      case (mode)
         0:       return 1'b1;
         1:       return (x >= 10) && (x <= 34);
         default: return (x < 10);
      endcase
   endfunction

   // Sends lines y0..y1-1; line 0 pixel 0 carries sof. duty!=0 inserts random
   // gaps with junk on the qualified inputs.
   task automatic send_rows(input int y0, input int y1, input int mode, input int duty);
      for (int y = y0; y < y1; y++) begin
         for (int x = 0; x < FW; x++) begin
            if (duty != 0) begin
               while ($urandom_range(1, 0) == 1)
                  drive(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                        1'($urandom_range(1, 0)));
            end
            drive(1'b1, (y == 0) && (x == 0), x == FW - 1, fg_of(mode, x));
         end
      end
   endtask

   task automatic check_frame(input string tag, input int ea, input int sa,
                              input int eb, input int sb);
      @(negedge dclk);
      pv = 1'b0; sof = 1'b0; eol = 1'b0; fg = 1'b0;
      chk({tag, " A valid"}, int'(ifa.sum_valid), 1);
      chk({tag, " A sum"},   int'(ifa.sum_row_out), ea);
      chk({tag, " A sat"},   int'(ifa.sat_flag), sa);
      chk({tag, " B valid"}, int'(ifb.sum_valid), 1);
      chk({tag, " B sum"},   int'(ifb.sum_row_out), eb);
      chk({tag, " B sat"},   int'(ifb.sat_flag), sb);
      @(negedge dclk);
      chk({tag, " A valid drop"}, int'(ifa.sum_valid), 0);
   endtask

   initial begin
      int s0, e0;
      idle(2);
      chk("reset sum", int'(ifa.sum_row_out), 0);
      chk("reset valid", int'(ifa.sum_valid), 0);
      chk("reset sat", int'(ifb.sat_flag), 0);
      chk("reset err", int'(ifa.frame_err), 0);
      clr = 1'b0;
      idle(2);

      s0 = sv_a; e0 = er_a;
      send_rows(0, FH, 0, 0);
      check_frame("allfg", 64, 0, 2047, 1);
      chk("allfg pulses", sv_a - s0, 1);
      chk("allfg no err", er_a - e0, 0);

      send_rows(0, FH, 1, 0);
      check_frame("band", 25, 0, 800, 0);

      s0 = sv_a;
      send_rows(0, FH, 1, 1);
      check_frame("band duty", 25, 0, 800, 0);
      chk("duty pulses", sv_a - s0, 1);

      // sof mid-frame: the partial all-fg frame must be discarded.
      e0 = er_a;
      send_rows(0, 40, 0, 0);
      chk("partial keeps sum", int'(ifa.sum_row_out), 25);
      send_rows(0, FH, 2, 0);
      check_frame("restart", 10, 0, 320, 0);
      chk("restart err A", er_a - e0, 1);
      chk("restart sum at err", err_sum_a, 25);

      // Early eol on line 10, then sof-less pixels must be ignored.
      s0 = sv_a; e0 = er_a;
      send_rows(0, 10, 0, 0);
      for (int x = 0; x <= 30; x++) drive(1'b1, 1'b0, x == 30, 1'b1);
      idle(3);
      chk("early eol err", er_a - e0, 1);
      chk("early eol err B", er_b - er_a, 0);
      for (int i = 0; i < 300; i++) drive(1'b1, 1'b0, (i % FW) == FW - 1, 1'b1);
      idle(3);
      chk("idle no valid", sv_a - s0, 0);
      chk("idle no err", er_a - e0, 1);
      chk("idle keeps sum", int'(ifa.sum_row_out), 10);

      // Line overrun: 65 pixels without eol.
      e0 = er_a;
      for (int x = 0; x <= FW; x++) drive(1'b1, x == 0, 1'b0, 1'b1);
      idle(3);
      chk("overrun err", er_a - e0, 1);
      chk("overrun keeps sum", int'(ifb.sum_row_out), 320);

      // Reset mid-frame, then a clean frame whose first pixel also carries eol.
      send_rows(0, 40, 0, 0);
      @(negedge dclk);
      pv = 1'b0;
      clr = 1'b1;
      #1;
      chk("clr sum A", int'(ifa.sum_row_out), 0);
      chk("clr sum B", int'(ifb.sum_row_out), 0);
      chk("clr sat B", int'(ifb.sat_flag), 0);
      chk("clr err", int'(ifa.frame_err), 0);
      idle(3);
      clr = 1'b0;
      idle(1);
      s0 = sv_a; e0 = er_a;
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      for (int x = 1; x < FW; x++) drive(1'b1, 1'b0, x == FW - 1, fg_of(2, x));
      send_rows(1, FH, 2, 0);
      check_frame("post clr", 10, 0, 320, 0);
      chk("post clr no err", er_a - e0, 0);
      chk("post clr pulses", sv_a - s0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got 0 expected 1");
      $fatal(1, "timeout");
   end

endmodule
